// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int ARB_REQUESTERS = 4;
    localparam int ARB_RESET_LAST = ARB_REQUESTERS - 1;

    // Reset value of the last-holder index, so the first scan starts at index 0.
    function automatic int arb_reset_last(input int requesters);
        return requesters - 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester and FIFO write-side signals of the arbiter, grouped as one bundle.
interface fifo_write_arbiter_if #(
    parameter int word_bits  = 8,
    parameter int requesters = 4,
    parameter int req_bits   = 2
);
    logic [requesters-1:0]           req_in;
    logic [requesters*word_bits-1:0] data_in;
    logic [requesters-1:0]           ack_out;
    logic                            fifo_full_in;
    logic [word_bits-1:0]            fifo_data_out;
    logic                            fifo_write_out;
    logic                            grant_valid_out;
    logic [req_bits-1:0]             grant_idx_out;

    modport master (
        output req_in, data_in, fifo_full_in,
        input  ack_out, fifo_data_out, fifo_write_out, grant_valid_out, grant_idx_out
    );

    modport slave (
        input  req_in, data_in, fifo_full_in,
        output ack_out, fifo_data_out, fifo_write_out, grant_valid_out, grant_idx_out
    );
endinterface

// File: rtl/fifo_write_arbiter_rr_select.sv
// Combinational round-robin picker: first set request at or after start_idx_i, wrapping.
module rr_select
    import fifo_arb_pkg::*;
#(
    parameter int requesters = 4,
    parameter int req_bits   = 2
) (
    input  logic [requesters-1:0] req_vec_i,
    input  logic [req_bits-1:0]   start_idx_i,
    output logic                  hit_o,
    output logic [req_bits-1:0]   sel_idx_o
);

    logic [req_bits-1:0] idx_s;

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        hit_o     = 1'b0;
        sel_idx_o = {req_bits{1'b0}};
        idx_s     = {req_bits{1'b0}};
        for (int k = requesters - 1; k >= 0; k--) begin
            idx_s = req_bits'((int'(start_idx_i) + k) % requesters);
            if (req_vec_i[idx_s]) begin
                hit_o     = 1'b1;
                sel_idx_o = idx_s;
            end else begin
                hit_o     = hit_o;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among several requesters.
// Define FIFO_ARB_BURST_EN to let a grant cover up to burst_len writes.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int word_bits  = 8,
    parameter int requesters = 4,
    parameter int req_bits   = 2,
    parameter int burst_len  = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    fifo_write_arbiter_if.slave bus
);

    localparam logic [req_bits-1:0] LAST_IDX = req_bits'(arb_reset_last(requesters));

    arb_state_e          state_q, state_d;
    logic [req_bits-1:0] sel_q, sel_d;
    logic [req_bits-1:0] last_q, last_d;
    logic [req_bits-1:0] base_s, start_s, pick_s;
    logic                hit_s, write_s, limit_s, grant_end_s;
    logic [requesters-1:0] ack_s;
    logic [word_bits-1:0]  wdata_s;
    logic [word_bits-1:0]  data_arr_s [requesters];

`ifdef FIFO_ARB_BURST_EN
    localparam int CNT_BITS = $clog2(burst_len) + 1;
    logic [CNT_BITS-1:0] burst_cnt_q, burst_cnt_d;
`else
    localparam int burst_len_unused = burst_len;
`endif

    for (genvar g = 0; g < requesters; g++) begin : g_data
        assign data_arr_s[g] = bus.data_in[g*word_bits +: word_bits];
    end

    // One picker serves both idle arbitration and end-of-grant handoff; the holder ranks last.
    assign base_s  = (state_q == ARB_GRANT) ? sel_q : last_q;
    assign start_s = (base_s == LAST_IDX) ? {req_bits{1'b0}} : base_s + 1'b1;

    rr_select #(
        .requesters (requesters),
        .req_bits   (req_bits)
    ) u_rr_select (
        .req_vec_i   (bus.req_in),
        .start_idx_i (start_s),
        .hit_o       (hit_s),
        .sel_idx_o   (pick_s)
    );

    assign write_s = (state_q == ARB_GRANT) && bus.req_in[sel_q] && !bus.fifo_full_in;

`ifdef FIFO_ARB_BURST_EN
    assign limit_s = (burst_cnt_q == CNT_BITS'(burst_len - 1));
`else
    assign limit_s = 1'b1;
`endif

    assign grant_end_s = !bus.req_in[sel_q] || (write_s && limit_s);

    // Write strobe, ack pulse and write data, all zero outside a write cycle.
    always_comb begin
        ack_s   = {requesters{1'b0}};
        wdata_s = {word_bits{1'b0}};
        if (write_s) begin
            ack_s[sel_q] = 1'b1;
            wdata_s      = data_arr_s[sel_q];
        end else begin
            ack_s = {requesters{1'b0}};
        end
    end

    assign bus.fifo_write_out  = write_s;
    assign bus.ack_out         = ack_s;
    assign bus.fifo_data_out   = wdata_s;
    assign bus.grant_valid_out = (state_q == ARB_GRANT);
    assign bus.grant_idx_out   = sel_q;

    // Next-state logic for grant acquisition, handoff and release.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
`ifdef FIFO_ARB_BURST_EN
        burst_cnt_d = burst_cnt_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (hit_s) begin
                    state_d = ARB_GRANT;
                    sel_d   = pick_s;
`ifdef FIFO_ARB_BURST_EN
                    burst_cnt_d = {CNT_BITS{1'b0}};
`endif
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (grant_end_s) begin
                    last_d = sel_q;
                    if (hit_s) begin
                        sel_d = pick_s;
`ifdef FIFO_ARB_BURST_EN
                        burst_cnt_d = {CNT_BITS{1'b0}};
`endif
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else begin
                    state_d = ARB_GRANT;
`ifdef FIFO_ARB_BURST_EN
                    if (write_s) begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end else begin
                        burst_cnt_d = burst_cnt_q;
                    end
`endif
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ARB_IDLE;
            sel_q   <= {req_bits{1'b0}};
            last_q  <= LAST_IDX;
`ifdef FIFO_ARB_BURST_EN
            burst_cnt_q <= {CNT_BITS{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
`ifdef FIFO_ARB_BURST_EN
            burst_cnt_q <= burst_cnt_d;
`endif
        end
    end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Shares the write port of one `fifo` instance among several requesters, such as the ACIA receive path, the monitor console and the debug port, using round-robin arbitration with a registered grant. Requester data is multiplexed onto the FIFO write port, and each accepted word is acknowledged with a one-cycle pulse. FIFO backpressure is respected without dropping words. The block sits directly in front of the shared FIFO's write side.

## Interface
- `word_bits`, 8: data width, which matches the FIFO.
- `requesters`, 4: number of requesters, at least 2.
- `req_bits`, 2: index width, equal to clog2(`requesters`).
- `burst_len`, 4: maximum consecutive writes per grant when burst mode is compiled in, at least 1.
- `clk_in` input 1: clock; all state changes on its rising edge.
- `rst_in` input 1: reset, asynchronous, active-low.
- `req_in` input `requesters`: per-requester write request, level; held until acknowledged.
- `data_in` input `requesters`×`word_bits`: requester i occupies bits [i·`word_bits` +: `word_bits`]; stable while `req_in`[i] is high.
- `ack_out` output `requesters`: one-cycle pulse per accepted word.
- `fifo_full_in` input 1: FIFO full flag.
- `fifo_data_out` output `word_bits`: FIFO write data.
- `fifo_write_out` output 1: FIFO write strobe.
- `grant_valid_out` output 1: a requester currently holds the grant.
- `grant_idx_out` output `req_bits`: index of the granted requester.

## Operation
- State machine with two states: ARB_IDLE and ARB_GRANT. Registers:
  - `sel`: the granted index.
  - `last`: the index of the last grant holder.
  - `burst_cnt`: clog2(`burst_len`)+1 bits.
- ARB_IDLE behaviour:
  - If any `req_in` bit is high, pick the first set bit scanning from `last`+1 upward, modulo `requesters`.
  - Load `sel` with that index, clear `burst_cnt`, and go to ARB_GRANT.
- A write occurs in ARB_GRANT when `req_in`[`sel`] is high and `fifo_full_in` is low. This is combinational. During a write cycle:
  - `fifo_write_out` is 1.
  - `ack_out`[`sel`] is 1.
  - `fifo_data_out` equals `data_in`[`sel`].
  - `burst_cnt` increments.
- Outside write cycles, `fifo_write_out`, all `ack_out` bits and `fifo_data_out` are 0.
- The grant ends when either of these holds:
  - `req_in`[`sel`] is low.
  - A write occurs and the burst limit is reached (see Configuration).
- On grant end, `last` is set to `sel`, then re-arbitration runs in the same edge:
  - Scan from `sel`+1 upward; `sel` itself has lowest priority.
  - Any hit: stay in ARB_GRANT with the new `sel` and `burst_cnt` = 0.
  - No hit: go to ARB_IDLE.
- If `fifo_full_in` is high while granted, the block stalls:
  - No write and no ack occur, and `burst_cnt` holds.
  - The grant is kept while `req_in`[`sel`] stays high.
  - If the requester withdraws during the stall, the grant ends without a write.
- `grant_valid_out` is 1 in ARB_GRANT; `grant_idx_out` equals `sel`.
- Reset, at any time including mid-burst:
  - Go to ARB_IDLE with `sel` = 0, `last` = `requesters`−1 and `burst_cnt` = 0.
  - All outputs are 0.
  - The first grant after reset goes to the lowest requesting index.

## Timing
- Request to first write takes 1 cycle from ARB_IDLE. Requester i raises `req_in` in cycle t; its write and ack occur in cycle t+1, provided the FIFO is not full.
- Handoff between requesters takes 0 idle cycles. A write can occur in every cycle while requests are pending and the FIFO is not full.
- The write strobe and ack are combinational from registered state plus `req_in` and `fifo_full_in`. The requester samples ack at the edge and may change data or drop `req_in` in the following cycle.
- A requester holding `req_in` high after an ack requests another word.
- FIFO full/not-full takes effect in the same cycle, so there is no over-write. A full-to-not-full change resumes writing in the same cycle.

## Configuration
- `FIFO_ARB_BURST_EN` defined: a grant covers up to `burst_len` writes and ends on the write that makes `burst_cnt` reach `burst_len`.
- `FIFO_ARB_BURST_EN` undefined:
  - Every grant ends after exactly one write, giving strict per-word round-robin.
  - `burst_cnt` and `burst_len` are unused.

## Structure
- Shared package `fifo_arb_pkg` contains:
  - The state enum (ARB_IDLE, ARB_GRANT).
  - Constant `ARB_RESET_LAST`, equal to `requesters`−1 as a function of the parameter.
- One sub-module, `rr_select`: a combinational round-robin picker.
  - Inputs: request vector and start index.
  - Outputs: hit flag and selected index.
  - Instantiated once; it serves both the ARB_IDLE and the end-of-grant arbitration paths.

## Test plan
- Reset: `rst_in`=0 mid-burst → all outputs are 0 and `grant_valid_out`=0 immediately. After release, with `req_in`=4'b1010, the first write is from requester 1.
- Fairness: `req_in`=4'b1111 held, FIFO never full, burst disabled → ack order is 0,1,2,3,0,1,… with one write per cycle.
- Burst: `FIFO_ARB_BURST_EN`, `burst_len`=4, `req_in`=4'b0011 held → acks 0,0,0,0,1,1,1,1,0.
- Backpressure: `fifo_full_in`=1 for 3 cycles mid-grant → no write and no ack during those cycles, grant held; the ack resumes in the first not-full cycle with `fifo_data_out` equal to the held data (e.g. 8'hA5).
- Withdraw: requester 2 drops `req_in` while stalled on full, with requester 3 pending → grant passes to 3 at that edge and no write from 2 occurs.
- Idle: `req_in`=0 after the last ack → state returns to ARB_IDLE, and a later request from index 0 is acked after 1 cycle.
